// File: rtl/mem_io_responder.sv
// CPU memory-port responder: byte RAM plus an I/O page at 0x30000 with a UART TX FIFO,
// an RX byte port, a free-running cycle counter and a sticky program-stop flag.
module mem_io_responder #(
   parameter int ADDR_BITS = 17,
   parameter int TX_DEPTH  = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_stop,
   output logic        tx_overflow
);

   localparam int PTR_W = $clog2(TX_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(TX_DEPTH);
   localparam logic [CNT_W-1:0] C_NEAR  = CNT_W'(TX_DEPTH - 1);

   logic [7:0]       r_ram [0:(1 << ADDR_BITS)-1];
   logic [7:0]       r_tx_buf [0:TX_DEPTH-1];
   logic [PTR_W-1:0] r_head, r_tail;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_counter;
   logic [23:0]      r_snap;
   logic [7:0]       r_mem_din;
   logic             r_stop, r_overflow;

   logic                 w_io, w_sel_ctr, w_push, w_pop, w_full, w_accept;
   logic [7:0]           w_push_data;
   logic [ADDR_BITS-1:0] w_idx;
   logic                 w_unused;

   assign w_unused = ^mem_a[31:18];

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_io        = (mem_a[17:16] == 2'b11);
      w_sel_ctr   = mem_a[2];
      w_idx       = mem_a[ADDR_BITS-1:0];
      w_push      = 1'b0;
      w_push_data = 8'h00;
      if (w_io && mem_wr) begin
         // The stop register always queues a 0x00 terminator; UART writes of 0x00 are ignored.
         w_push      = w_sel_ctr || (mem_dout != 8'h00);
         w_push_data = w_sel_ctr ? 8'h00 : mem_dout;
      end
      w_pop    = tx_valid && tx_ready;
      w_full   = (r_count == C_DEPTH);
      w_accept = w_push && (!w_full || w_pop);
   end

   assign tx_valid       = (r_count != '0);
   assign tx_data        = tx_valid ? r_tx_buf[r_head] : 8'h00;
   assign io_buffer_full = (r_count >= C_NEAR);
   assign rx_pop         = rst_in && w_io && !mem_wr && !w_sel_ctr && rx_valid;
   assign mem_din        = r_mem_din;
   assign program_stop   = r_stop;
   assign tx_overflow    = r_overflow;

   // NOTE: storage arrays carry no reset; their contents are undefined until written.
   always_ff @(posedge clk_in) begin
      if (!w_io && mem_wr) r_ram[w_idx] <= mem_dout;
      if (w_accept)        r_tx_buf[r_tail] <= w_push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) r_tail <= r_tail + 1'b1;
         if (w_pop)    r_head <= r_head + 1'b1;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_counter <= '0;
         r_snap    <= '0;
         r_mem_din <= 8'h00;
         r_stop    <= 1'b0;
      end else begin
         r_counter <= r_counter + 1'b1;
         if (w_io && mem_wr && w_sel_ctr) r_stop <= 1'b1;
         if (!mem_wr) begin
            if (!w_io) begin
               r_mem_din <= r_ram[w_idx];
            end else if (!w_sel_ctr) begin
               r_mem_din <= rx_valid ? rx_data : 8'h00;
            end else begin
               // Byte 0 latches the upper bytes so an ascending dword read is coherent.
               case (mem_a[1:0])
                  2'd0: begin
                     r_mem_din <= r_counter[7:0];
                     r_snap    <= r_counter[31:8];
                  end
                  2'd1:    r_mem_din <= r_snap[7:0];
                  2'd2:    r_mem_din <= r_snap[15:8];
                  default: r_mem_din <= r_snap[23:16];
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, TX FIFO limits, RX port,
// cycle-counter snapshot, program stop and asynchronous reset.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] mem_a = '0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_dout = '0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_pop;
   logic        program_stop;
   logic        tx_overflow;

   int n_tests = 0;
   int n_fail  = 0;

   mem_io_responder #(.ADDR_BITS(17), .TX_DEPTH(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
      .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .program_stop(program_stop), .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [7:0] d);
      mem_a = a; mem_wr = 1'b1; mem_dout = d;
      step();
   endtask

   task automatic do_read(input logic [31:0] a);
      mem_a = a; mem_wr = 1'b0;
      step();
   endtask

   task automatic idle;
      do_read(32'h0000_0000);
   endtask

   task automatic apply_reset;
      mem_a = '0; mem_wr = 1'b0; mem_dout = '0; tx_ready = 1'b0; rx_valid = 1'b0;
      rst_in = 1'b0;
      #12;
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   initial begin
      logic [7:0] exp_b;

      // Reset state, with a UART read pending to show rx_pop stays low in reset.
      mem_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'h77;
      #12;
      check("rst_mem_din", mem_din, 8'h00);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_full", io_buffer_full, 1'b0);
      check("rst_stop", program_stop, 1'b0);
      check("rst_ovf", tx_overflow, 1'b0);
      check("rst_rx_pop", rx_pop, 1'b0);
      apply_reset();

      // RAM read-after-write, hold on write, alias and top byte.
      do_write(32'h0000_0010, 8'hA5);
      do_read(32'h0000_0010);
      check("ram_raw", mem_din, 8'hA5);
      do_write(32'h0000_0020, 8'h11);
      check("ram_hold_on_write", mem_din, 8'hA5);
      do_write(32'h0001_FFFF, 8'h3C);
      do_read(32'h0001_FFFF);
      check("ram_top", mem_din, 8'h3C);
      do_write(32'h0000_FFFF, 8'h5A);
      do_read(32'h0002_FFFF);
      check("ram_alias", mem_din, 8'h5A);
      do_read(32'h0000_0020);
      check("ram_other", mem_din, 8'h11);

      // UART TX: 0x00 ignored, then drain in order.
      tx_ready = 1'b0;
      do_write(32'h0003_0000, 8'h41);
      do_write(32'h0003_0000, 8'h00);
      do_write(32'h0003_0001, 8'h42);
      check("tx_head0", tx_data, 8'h41);
      check("tx_valid0", tx_valid, 1'b1);
      check("tx_full0", io_buffer_full, 1'b0);
      tx_ready = 1'b1;
      idle();
      check("tx_head1", tx_data, 8'h42);
      check("tx_valid1", tx_valid, 1'b1);
      idle();
      check("tx_empty", tx_valid, 1'b0);
      tx_ready = 1'b0;

      // Full / overflow boundaries.
      for (int i = 1; i <= 16; i++) begin
         do_write(32'h0003_0000, 8'(i));
         if (i == 14) check("full_at14", io_buffer_full, 1'b0);
         if (i == 15) check("full_at15", io_buffer_full, 1'b1);
      end
      check("ovf_at16", tx_overflow, 1'b0);
      tx_ready = 1'b1;
      do_write(32'h0003_0000, 8'h99);
      check("pushpop_ovf", tx_overflow, 1'b0);
      check("pushpop_head", tx_data, 8'h02);
      check("pushpop_full", io_buffer_full, 1'b1);
      tx_ready = 1'b0;
      do_write(32'h0003_0000, 8'hEE);
      check("ovf_drop", tx_overflow, 1'b1);
      tx_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         exp_b = (k < 15) ? 8'(k + 2) : 8'h99;
         check($sformatf("drain_data%0d", k), tx_data, exp_b);
         check($sformatf("drain_full%0d", k), io_buffer_full, ((16 - k) >= 15) ? 1'b1 : 1'b0);
         idle();
      end
      check("drain_empty", tx_valid, 1'b0);
      check("ovf_sticky", tx_overflow, 1'b1);
      tx_ready = 1'b0;

      // RX port.
      rx_data = 8'h37; rx_valid = 1'b1;
      mem_a = 32'h0003_0000; mem_wr = 1'b0;
      #1;
      check("rx_pop_hi", rx_pop, 1'b1);
      @(posedge clk_in); #1;
      rx_valid = 1'b0; mem_a = 32'h0000_0000;
      #1;
      check("rx_data", mem_din, 8'h37);
      check("rx_pop_lo", rx_pop, 1'b0);
      mem_a = 32'h0003_0002;
      #1;
      check("rx_nopop", rx_pop, 1'b0);
      step();
      check("rx_empty_read", mem_din, 8'h00);

      // Counter: value 1 after the first edge.
      apply_reset();
      idle();
      do_read(32'h0003_0004);
      check("ctr_first", mem_din, 8'h01);

      // Counter snapshot at 0x000102FF.
      apply_reset();
      repeat (32'h0001_02FF) @(posedge clk_in);
      #1;
      do_read(32'h0003_0004);
      check("ctr_b0", mem_din, 8'hFF);
      do_read(32'h0003_0005);
      check("ctr_b1", mem_din, 8'h02);
      do_read(32'h0003_0006);
      check("ctr_b2", mem_din, 8'h01);
      do_read(32'h0003_0007);
      check("ctr_b3", mem_din, 8'h00);

      // Program stop queues a terminator.
      do_write(32'h0003_0004, 8'h55);
      check("stop_set", program_stop, 1'b1);
      check("stop_term_valid", tx_valid, 1'b1);
      check("stop_term_data", tx_data, 8'h00);
      do_read(32'h0000_0010);
      check("stop_sticky", program_stop, 1'b1);
      check("ram_survives_reset", mem_din, 8'hA5);

      // Asynchronous reset in the middle of a read.
      mem_a = 32'h0003_0000; mem_wr = 1'b0; rx_data = 8'h66; rx_valid = 1'b1;
      #2;
      rst_in = 1'b0;
      #1;
      check("arst_mem_din", mem_din, 8'h00);
      check("arst_tx_valid", tx_valid, 1'b0);
      check("arst_tx_data", tx_data, 8'h00);
      check("arst_full", io_buffer_full, 1'b0);
      check("arst_stop", program_stop, 1'b0);
      check("arst_ovf", tx_overflow, 1'b0);
      check("arst_rx_pop", rx_pop, 1'b0);
      rx_valid = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
